instr_fetch_unit: RTL

//   Requester side of the instruction memory interface.
//   - Holds the program counter and drives the word address into the combinational instruction memory.
//   - Captures the returned word and queues {pc, instr} in a small FIFO.
//   - Hands the queued words to the decode stage over a valid/ready handshake.
//   - Accepts branch/jump redirects from execute; a redirect flushes the queue.

---
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: requester side of the instruction memory interface.
// Holds the PC, captures the combinationally returned word and queues {pc, instr}
// in a DEPTH-entry FIFO that drains to decode over a valid/ready handshake.
// A redirect from execute flushes the queue and reloads the PC.
// Optional build macro: FETCH_ALIGN_CHECK_EN enables the sticky misaligned-redirect fault.
//   Defined:   a misaligned redirect sets fault, loads pc unchanged and halts fetch until reset.
//   Undefined: redirect_pc[1:0] are forced to zero and fault is tied low.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned PTR_W    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam int unsigned      CntW     = PTR_W + 1;
    localparam logic [CntW-1:0]  DepthCnt = CntW'(DEPTH);
    localparam logic [PTR_W-1:0] LastPtr  = PTR_W'(DEPTH - 1);

    // Program counter and queue control state
    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Queue storage; reset to zero so the head reads 0 while empty after reset
    logic [31:0] q_pc_q    [DEPTH];
    logic [31:0] q_instr_q [DEPTH];

    logic        push;
    logic        pop;
    logic        fault_int;
    logic [31:0] redirect_target;

    // Pointers wrap modulo DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    logic misaligned;

    assign misaligned      = redirect_valid & (redirect_pc[1:0] != 2'b00);
    // A misaligned target is loaded as-is; fetch is halted by the fault anyway
    assign redirect_target = redirect_pc;
    assign fault_int       = fault_q;

    // Sticky fault: set by a misaligned redirect, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (misaligned) begin
            fault_q <= 1'b1;
        end
    end
`else
    logic unused_redirect_low;

    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign fault_int           = 1'b0;
    assign unused_redirect_low = ^redirect_pc[1:0];
`endif

    assign pop  = out_valid & out_ready;
    assign push = fetch_en & ~redirect_valid & ~fault_int & ((count_q < DepthCnt) | pop);

    // Next-state for PC, pointers and occupancy; redirect overrides push and pop
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = redirect_target;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage: capture {pc, imem_data} at the write pointer on push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else if (push) begin
            q_pc_q[wr_ptr_q]    <= pc_q;
            q_instr_q[wr_ptr_q] <= imem_data;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = q_pc_q[rd_ptr_q];
    assign out_instr = q_instr_q[rd_ptr_q];
    assign fault     = fault_int;

endmodule
